// File: rtl/reg_share_arb.sv
// reg_share_arb
// Round-robin arbiter and sequencer that shares one WIDTH-bit register
// between two requesters. A granted requester's operation (load, clear,
// preset or hold) is applied on the closing edge of a one-cycle EXEC state.
// A one-cycle DONE state follows, and done pulses during DONE.
//
// Optional feature macro: REG_SHARE_ARB_LOCK_EN
//   When defined, a 2-bit lock input lets the granted requester chain
//   back-to-back operations without rearbitration (DONE -> EXEC).
//   When undefined, the lock port does not exist and DONE always returns
//   to IDLE.
//
// Ports:
//   clk   in   1      system clock, rising edge
//   clr   in   1      asynchronous active-low reset
//   req   in   2      request lines, bit i belongs to requester i
//   op0   in   2      requester 0 op: 00 load, 01 clear, 10 preset, 11 hold
//   op1   in   2      requester 1 op, same encoding
//   d0    in   WIDTH  requester 0 load data
//   d1    in   WIDTH  requester 1 load data
//   lock  in   2      (REG_SHARE_ARB_LOCK_EN only) per-requester lock
//   gnt   out  2      one-hot grant, zero when idle
//   busy  out  1      high whenever the sequencer is not idle
//   done  out  1      one-cycle pulse after the operation is applied
//   q     out  WIDTH  shared register value
module reg_share_arb #(
  parameter int               WIDTH      = 8,
  parameter logic [WIDTH-1:0] RESET_VAL  = '0,
  parameter logic [WIDTH-1:0] PRESET_VAL = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [1:0]       req,
  input  logic [1:0]       op0,
  input  logic [1:0]       op1,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
`ifdef REG_SHARE_ARB_LOCK_EN
  input  logic [1:0]       lock,
`endif
  output logic [1:0]       gnt,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] q
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_EXEC = 2'b01,
    S_DONE = 2'b10
  } state_t;

  localparam logic [1:0] OP_LOAD   = 2'b00;
  localparam logic [1:0] OP_CLEAR  = 2'b01;
  localparam logic [1:0] OP_PRESET = 2'b10;

  state_t           state;
  logic             sel;
  logic             last;
  logic             winner;
  logic             lock_again;
  logic [1:0]       sel_op;
  logic [WIDTH-1:0] sel_d;

  // On a tie the requester that was not served last wins; a single
  // request always wins outright.
  always_comb begin
    winner = 1'b0;
    case (req)
      2'b01:   winner = 1'b0;
      2'b10:   winner = 1'b1;
      2'b11:   winner = ~last;
      default: winner = 1'b0;
    endcase
  end

  // Only the selected requester's op and data can reach the register.
  assign sel_op = sel ? op1 : op0;
  assign sel_d  = sel ? d1  : d0;

`ifdef REG_SHARE_ARB_LOCK_EN
  assign lock_again = lock[sel] & req[sel];
`else
  assign lock_again = 1'b0;
`endif

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state <= S_IDLE;
      sel   <= 1'b0;
      last  <= 1'b1;
      gnt   <= 2'b00;
      busy  <= 1'b0;
      done  <= 1'b0;
      q     <= RESET_VAL;
    end else begin
      case (state)
        S_IDLE: begin
          if (req != 2'b00) begin
            sel   <= winner;
            gnt   <= winner ? 2'b10 : 2'b01;
            busy  <= 1'b1;
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          // Hold leaves q untouched, so it needs no case arm.
          case (sel_op)
            OP_LOAD:   q <= sel_d;
            OP_CLEAR:  q <= '0;
            OP_PRESET: q <= PRESET_VAL;
            default:   ;
          endcase
          last  <= sel;
          done  <= 1'b1;
          state <= S_DONE;
        end
        S_DONE: begin
          done <= 1'b0;
          // A locked requester keeps its grant and re-enters EXEC directly.
          if (lock_again) begin
            state <= S_EXEC;
          end else begin
            gnt   <= 2'b00;
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: begin
          gnt   <= 2'b00;
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/reg_share_arb.md
Name: reg_share_arb

Overview:
- Round-robin arbiter and sequencer that shares one WIDTH-bit D-flip-flop register between two requesters.
- Each requester issues one of four operations on the shared register: load, clear, preset or hold.
- The block grants one requester at a time, applies its operation on a fixed clock edge and pulses done.
- Sits between two control units and a register that has preset/clear capability.

Parameters:
- WIDTH, 8: bit width of the shared register and of the data inputs.
- RESET_VAL, 0: value q takes on reset.
- PRESET_VAL, all ones ({WIDTH{1'b1}}): value q takes on a preset op.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- clr  input  1  asynchronous active-low reset.
- req  input  2  request lines; bit i belongs to requester i.
- op0  input  2  requester 0 operation: 00 load, 01 clear, 10 preset, 11 hold.
- op1  input  2  requester 1 operation, same encoding as op0.
- d0  input  WIDTH  requester 0 load data.
- d1  input  WIDTH  requester 1 load data.
- gnt  output  2  one-hot grant; zero when idle.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse: the granted operation has been applied.
- q  output  WIDTH  shared register value.

Behaviour:
- Reset (clr low, asynchronous, any state, including mid-operation):
  - state=IDLE, gnt=00, busy=0, done=0, q=RESET_VAL, last=1.
  - With last=1, requester 0 wins the first tie.
  - Release of reset is synchronous to clk.
- State IDLE: gnt=00.
  - req=00: stay in IDLE.
  - Exactly one req bit set: grant that requester.
  - req=11: grant the requester not equal to last.
  - On a grant: sel <= winner, gnt <= onehot(winner), state <= EXEC.
- State EXEC (exactly one cycle): on the closing edge, q is updated from the sel requester's op/data:
  - load: q <= d_sel.
  - clear: q <= 0.
  - preset: q <= PRESET_VAL.
  - hold: q unchanged.
  - Also on that edge: last <= sel, state <= DONE.
  - op and d are sampled only on this edge. Changes at any other time have no effect.
- State DONE (exactly one cycle):
  - done=1; gnt is held.
  - Next state is IDLE unconditionally.
- Latency: req sampled high on edge N → gnt high after edge N → q updated at edge N+1 → done high between edges N+1 and N+2 → IDLE after edge N+2. Sustained throughput is one op per 3 cycles.
- Requests are level-based: a req still high in IDLE is a new request.
  - Under sustained req=11, grants strictly alternate 0,1,0,1.
- req dropped during EXEC or DONE: the operation still completes and done still pulses (no abort).
- The ungranted requester's inputs never affect q.
- gnt is always one-hot or zero; gnt=11 never occurs.

Optional Feature:
- Macro: REG_SHARE_ARB_LOCK_EN.
- Defined:
  - Adds input lock (2 bits).
  - In DONE, if lock[sel]=1 and req[sel]=1, next state is EXEC for the same requester: gnt held, no rearbitration, last unchanged.
  - Back-to-back locked ops take 2 cycles each.
  - When lock drops, the block returns to IDLE and normal round-robin resumes, with last=sel.
- Not defined: the lock port does not exist and DONE always goes to IDLE.

Test Plan:
- Reset mid-EXEC: clr low while gnt=01 → q=RESET_VAL (0x00), gnt=00, busy=0, done=0 immediately, without waiting for a clock edge.
- Single request: req=01, op0=00, d0=0xA5 → gnt=01 one cycle after sampling, q=0xA5 after the next edge, then a done pulse one cycle wide, then gnt=00.
- Tie after reset: req=11 with op0=clear, op1=preset held for 6 cycles → first grant 01 (q=0x00), then 10 (q=0xFF), both with done pulses.
- Hold and isolation: requester 1 granted with op1=11 while d0 and op0 toggle → q unchanged through done.
- Request dropped: req=10 deasserted during EXEC with op1=load, d1=0x3C → q=0x3C and done still pulses.
- With REG_SHARE_ARB_LOCK_EN: req=11, lock=01 → requester 0 is granted on consecutive EXECs. After lock drops, the next grant goes to requester 1.
